// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SHW registered stages, stage k shifts by 2^(SHW-1-k).
// Supports LSL, LSR, ASR and rotate-left, with an OR of all bits shifted out.
module pipelined_barrel_shifter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_lost,
    output logic [1:0]       out_mode
);

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;

    // Global advance: the whole pipe moves unless the result is blocked.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        // Shamt bits still pending at this stage's input; the MSB is consumed here.
        localparam int unsigned SRC_W = SHW - k;
        localparam int unsigned SH    = 1 << (SRC_W - 1);
        localparam logic [WIDTH-1:0] LOW_MASK = {{(WIDTH - SH){1'b0}}, {SH{1'b1}}};

        logic             src_vld;
        logic [WIDTH-1:0] src_data;
        logic [SRC_W-1:0] src_shamt;
        logic [1:0]       src_mode;
        logic             src_lost;

        logic [WIDTH-1:0] nxt_data;
        logic             nxt_lost;

        logic             vld_q;
        logic [WIDTH-1:0] data_q;
        logic [1:0]       mode_q;
        logic             lost_q;

        if (k == 0) begin : g_src
            assign src_vld   = in_valid;
            assign src_data  = in_data;
            assign src_shamt = in_shamt;
            assign src_mode  = in_mode;
            assign src_lost  = 1'b0;
        end else begin : g_src
            assign src_vld   = g_stage[k-1].vld_q;
            assign src_data  = g_stage[k-1].data_q;
            assign src_shamt = g_stage[k-1].g_rem.shamt_q;
            assign src_mode  = g_stage[k-1].mode_q;
            assign src_lost  = g_stage[k-1].lost_q;
        end

        // Conditional shift by SH; ASR keeps replicating the original sign bit.
        always_comb begin
            nxt_data = src_data;
            nxt_lost = src_lost;
            if (src_shamt[SRC_W-1]) begin
                case (src_mode)
                    MODE_LSL: begin
                        nxt_data = src_data << SH;
                        nxt_lost = src_lost | (|(src_data >> (WIDTH - SH)));
                    end
                    MODE_LSR: begin
                        nxt_data = src_data >> SH;
                        nxt_lost = src_lost | (|(src_data & LOW_MASK));
                    end
                    MODE_ASR: begin
                        nxt_data = WIDTH'($signed(src_data) >>> SH);
                        nxt_lost = src_lost | (|(src_data & LOW_MASK));
                    end
                    default: begin
                        nxt_data = (src_data << SH) | (src_data >> (WIDTH - SH));
                        nxt_lost = 1'b0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q  <= 1'b0;
                data_q <= '0;
                mode_q <= 2'b00;
                lost_q <= 1'b0;
            end else if (adv) begin
                vld_q  <= src_vld;
                data_q <= nxt_data;
                mode_q <= src_mode;
                lost_q <= nxt_lost;
            end
        end

        // Only the not-yet-consumed shamt bits travel on; the last stage has none.
        if (SRC_W > 1) begin : g_rem
            logic [SRC_W-2:0] shamt_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    shamt_q <= '0;
                end else if (adv) begin
                    shamt_q <= src_shamt[SRC_W-2:0];
                end
            end
        end
    end

    assign out_valid = g_stage[SHW-1].vld_q;
    assign out_data  = g_stage[SHW-1].data_q;
    assign out_lost  = g_stage[SHW-1].lost_q;
    assign out_mode  = g_stage[SHW-1].mode_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: directed vectors at WIDTH=32 and WIDTH=8,
// stall/reset sequences and a random stream against a reference model.
module tb_pipelined_barrel_shifter;

    logic clk;
    logic rst_n;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_lost;
    logic [31:0] a_in_data, a_out_data;
    logic [4:0]  a_in_shamt;
    logic [1:0]  a_in_mode, a_out_mode;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_lost;
    logic [7:0]  b_in_data, b_out_data;
    logic [2:0]  b_in_shamt;
    logic [1:0]  b_in_mode, b_out_mode;

    int n_cmp;
    int n_bad;

    pipelined_barrel_shifter #(.WIDTH(32)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_shamt(a_in_shamt), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_lost(a_out_lost), .out_mode(a_out_mode)
    );

    pipelined_barrel_shifter #(.WIDTH(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_shamt(b_in_shamt), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_lost(b_out_lost), .out_mode(b_out_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        narrow;
        logic [1:0]  mode;
        logic [31:0] data;
        logic [4:0]  shamt;
        logic [31:0] exp_data;
        logic        exp_lost;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        lost;
        logic [1:0]  mode;
    } res_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: shift the whole word with wide arithmetic, then mask to width.
    function automatic res_t model(input logic [31:0] din, input int sh, input logic [1:0] m, input int w);
        logic [63:0] mask;
        logic [63:0] d;
        logic [63:0] full;
        res_t r;
        mask = (64'd1 << w) - 64'd1;
        d    = {32'd0, din} & mask;
        r.mode = m;
        r.lost = 1'b0;
        case (m)
            2'd0: begin
                full   = d << sh;
                r.data = 32'(full & mask);
                r.lost = (full >> w) != 64'd0;
            end
            2'd1: begin
                r.data = 32'(d >> sh);
                r.lost = (d & ((64'd1 << sh) - 64'd1)) != 64'd0;
            end
            2'd2: begin
                full = d >> sh;
                if (d[w-1]) full = full | (mask & ~(mask >> sh));
                r.data = 32'(full);
                r.lost = (d & ((64'd1 << sh) - 64'd1)) != 64'd0;
            end
            default: begin
                r.data = 32'(((d << sh) | (d >> (w - sh))) & mask);
            end
        endcase
        return r;
    endfunction

    // Push one item into the chosen DUT and check latency, result and drain.
    task automatic run_one(input vec_t v);
        int cyc;
        int lat;
        logic ov;
        if (v.narrow) begin
            b_in_valid = 1'b1; b_in_data = v.data[7:0]; b_in_shamt = v.shamt[2:0];
            b_in_mode = v.mode; b_out_ready = 1'b1;
        end else begin
            a_in_valid = 1'b1; a_in_data = v.data; a_in_shamt = v.shamt;
            a_in_mode = v.mode; a_out_ready = 1'b1;
        end
        lat = v.narrow ? 3 : 5;
        #1;
        check("in_ready_idle", 64'(v.narrow ? b_in_ready : a_in_ready), 64'd1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        cyc = 1;
        ov = v.narrow ? b_out_valid : a_out_valid;
        while (!ov && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            ov = v.narrow ? b_out_valid : a_out_valid;
        end
        check("latency", 64'(cyc), 64'(lat));
        check("out_data", 64'(v.narrow ? {24'd0, b_out_data} : a_out_data), 64'(v.exp_data));
        check("out_lost", 64'(v.narrow ? b_out_lost : a_out_lost), 64'(v.exp_lost));
        check("out_mode", 64'(v.narrow ? b_out_mode : a_out_mode), 64'(v.mode));
        @(posedge clk); #1;
        check("drained", 64'(v.narrow ? b_out_valid : a_out_valid), 64'd0);
    endtask

    vec_t vecs[15];

    initial begin
        int   pushed;
        int   popped;
        int   cyc;
        logic push;
        logic prev_stall;
        res_t prev;
        res_t exp;
        res_t q[$];
        logic [31:0] held;

        n_cmp = 0;
        n_bad = 0;

        vecs[0]  = '{1'b0, 2'd0, 32'h8000_0001, 5'd4,  32'h0000_0010, 1'b1};
        vecs[1]  = '{1'b0, 2'd2, 32'h8000_00F0, 5'd4,  32'hF800_000F, 1'b0};
        vecs[2]  = '{1'b0, 2'd1, 32'h8000_00F0, 5'd5,  32'h0400_0007, 1'b1};
        vecs[3]  = '{1'b0, 2'd3, 32'h1234_5678, 5'd8,  32'h3456_7812, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0};
        vecs[5]  = '{1'b0, 2'd0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{1'b0, 2'd1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
        vecs[7]  = '{1'b0, 2'd2, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{1'b0, 2'd3, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0};
        vecs[9]  = '{1'b1, 2'd0, 32'h0000_0081, 5'd4,  32'h0000_0010, 1'b1};
        vecs[10] = '{1'b1, 2'd2, 32'h0000_00F0, 5'd4,  32'h0000_00FF, 1'b0};
        vecs[11] = '{1'b1, 2'd1, 32'h0000_00F0, 5'd5,  32'h0000_0007, 1'b1};
        vecs[12] = '{1'b1, 2'd3, 32'h0000_0081, 5'd1,  32'h0000_0003, 1'b0};
        vecs[13] = '{1'b1, 2'd0, 32'h0000_0001, 5'd7,  32'h0000_0080, 1'b0};
        vecs[14] = '{1'b1, 2'd3, 32'h0000_0012, 5'd4,  32'h0000_0021, 1'b0};

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_shamt = '0; a_in_mode = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_shamt = '0; b_in_mode = '0; b_out_ready = 1'b0;
        #1;
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_out_data", 64'(a_out_data), 64'd0);
        check("rst_out_lost_mode", 64'({a_out_lost, a_out_mode}), 64'd0);
        check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_one(vecs[i]);

        // Stall at the output: results hold and in_ready drops.
        a_in_valid = 1'b1; a_in_data = 32'h8000_00F0; a_in_shamt = 5'd4; a_in_mode = 2'd2;
        a_out_ready = 1'b0;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        cyc = 1;
        while (!a_out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("stall_latency", 64'(cyc), 64'd5);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 64'(a_out_valid), 64'd1);
            check("stall_data", 64'(a_out_data), 64'hF800_000F);
            check("stall_in_ready", 64'(a_in_ready), 64'd0);
        end
        a_out_ready = 1'b1;
        #1;
        check("release_in_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk); #1;
        check("release_drained", 64'(a_out_valid), 64'd0);

        // Random back-to-back stream with random backpressure.
        pushed = 0;
        popped = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev = '{32'd0, 1'b0, 2'd0};
        a_in_valid = 1'b0;
        while ((pushed < 20 || popped < 20) && cyc < 600) begin
            if (!a_in_valid && pushed < 20 && $urandom_range(0, 3) != 0) begin
                a_in_valid = 1'b1;
                held       = $urandom;
                a_in_data  = held;
                a_in_shamt = 5'($urandom_range(0, 31));
                a_in_mode  = 2'($urandom_range(0, 3));
            end
            a_out_ready = 1'($urandom_range(0, 1));
            #1;
            check("rand_in_ready", 64'(a_in_ready), 64'(!(a_out_valid && !a_out_ready)));
            if (prev_stall) begin
                check("rand_hold_valid", 64'(a_out_valid), 64'd1);
                check("rand_hold_result", 64'({a_out_lost, a_out_mode, a_out_data}),
                      64'({prev.lost, prev.mode, prev.data}));
            end
            if (a_out_valid && a_out_ready) begin
                if (q.size() == 0) begin
                    check("rand_unexpected_pop", 64'd1, 64'd0);
                end else begin
                    exp = q.pop_front();
                    check("rand_data", 64'(a_out_data), 64'(exp.data));
                    check("rand_lost", 64'(a_out_lost), 64'(exp.lost));
                    check("rand_mode", 64'(a_out_mode), 64'(exp.mode));
                end
                popped++;
            end
            push = a_in_valid && a_in_ready;
            if (push) begin
                q.push_back(model(a_in_data, int'(a_in_shamt), a_in_mode, 32));
                pushed++;
            end
            prev_stall = a_out_valid && !a_out_ready;
            prev = '{a_out_data, a_out_lost, a_out_mode};
            @(posedge clk); #1;
            if (push) a_in_valid = 1'b0;
            cyc++;
        end
        check("rand_pushed", 64'(pushed), 64'd20);
        check("rand_popped", 64'(popped), 64'd20);
        check("rand_queue_empty", 64'(q.size()), 64'd0);
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset with three items in flight, one already at the output.
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in_valid = 1'b1; a_in_data = 32'h0000_1000 << i; a_in_shamt = 5'd1; a_in_mode = 2'd0;
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
        cyc = 0;
        while (!a_out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("pre_reset_valid", 64'(a_out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(a_out_valid), 64'd0);
        check("async_rst_in_ready", 64'(a_in_ready), 64'd1);
        check("async_rst_data", 64'({a_out_lost, a_out_mode, a_out_data}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_one('{1'b0, 2'd1, 32'hFFFF_FFFF, 5'd16, 32'h0000_FFFF, 1'b1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
PIPELINED_BARREL_SHIFTER -- requirements
Module: pipelined_barrel_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width; legal values are powers of two, minimum 4.
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH): shift-amount width and pipeline depth.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the input operand is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the operand this cycle.
REQ-007 SHALL have port in_data, input, WIDTH bits: operand.
REQ-008 SHALL have port in_shamt, input, SHW bits: shift amount, 0 to WIDTH-1.
REQ-009 SHALL have port in_mode, input, 2 bits: operation; 00 LSL, 01 LSR, 10 ASR, 11 ROL (rotate left).
REQ-010 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-012 SHALL have port out_data, output, WIDTH bits: shifted result.
REQ-013 SHALL have port out_lost, output, 1 bit: OR of all bits shifted out; always 0 for ROL.
REQ-014 SHALL have port out_mode, output, 2 bits: the mode of the result, carried through the pipeline.

Function
REQ-015 SHALL implement SHW registered stages; stage k (k=0 first) conditionally shifts by 2^(SHW-1-k), using shamt bit SHW-1-k.
- Shift order: largest first.
REQ-016 Each stage register SHALL hold valid, data, remaining shamt bits, mode and accumulated lost bit.
REQ-017 Latency SHALL be exactly SHW cycles from an accepted input to out_valid, when out_ready is held high.
REQ-018 Sustained throughput SHALL be one result per cycle when out_ready=1.
REQ-019 Pipeline advance SHALL be defined as adv = !out_valid || out_ready; in_ready SHALL equal adv (combinational, no dependence on in_valid).
REQ-020 When adv=1, every stage SHALL load from its predecessor; stage 0 loads in_valid and the input fields. When adv=0, all stages SHALL hold.
- Stall is global; bubbles are not collapsed.
REQ-021 A transfer SHALL occur on in_valid&&in_ready at input and on out_valid&&out_ready at output.
REQ-022 out_data, out_lost and out_mode SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 Shift fill rules per mode:
- LSL and LSR zero-fill.
- ASR fills with in_data[WIDTH-1].
- ROL re-inserts the bits shifted out.
REQ-024 Lost bits by mode:
- LSL: the top bits removed.
- LSR and ASR: the low bits removed.
- out_lost SHALL be the OR of these bits across all stages.
REQ-025 shamt=0 SHALL pass data unchanged with out_lost=0 in every mode.
REQ-026 Stage data registers SHALL update only on adv; valid bits SHALL clear when a bubble enters.
- Result fields of invalid stages are don't-care but SHALL not affect valid results.
REQ-027 Simultaneous output pop and input push under adv=1 SHALL lose or duplicate no items.

Reset
REQ-028 On rst_n=0, all stage valid bits SHALL clear immediately (asynchronous): out_valid=0, in_ready=1.
- out_data, out_lost and out_mode SHALL reset to 0.
REQ-029 Reset mid-operation SHALL discard all in-flight items.
- The first accepted item after rst_n rises SHALL appear SHW cycles later.
REQ-030 Reset deassertion SHALL be synchronised externally; the block SHALL not require a cycle to recover after rst_n=1.

Verification
REQ-031 WIDTH=32, LSL, in_data=0x8000_0001, shamt=4: out_data=0x0000_0010, out_lost=1, 5 cycles after acceptance.
REQ-032 WIDTH=32, ASR, in_data=0x8000_00F0, shamt=4: out_data=0xF800_000F, out_lost=0.
- Same operand with LSR, shamt=5: out_data=0x0400_0007, out_lost=1.
REQ-033 ROL, in_data=0x1234_5678, shamt=8: out_data=0x3456_7812, out_lost=0.
- shamt=31 on 0x0000_0001 with LSL: out_data=0x8000_0000, out_lost=0.
REQ-034 Back-to-back stream of 20 random items with out_ready toggled pseudo-randomly: results SHALL match the reference model in order with none lost or duplicated.
- in_ready SHALL fall exactly when out_valid=1 and out_ready=0.
REQ-035 Assert rst_n=0 with 3 items in flight: out_valid SHALL drop in the same cycle.
- After release, one item (LSR, 0xFFFF_FFFF, shamt=16) SHALL yield 0x0000_FFFF, out_lost=1, 5 cycles after acceptance.
REQ-036 Run the REQ-031 to REQ-033 scenarios at WIDTH=8 (SHW=3) and check a latency of 3 cycles.
- ROL, in_data=0x81, shamt=1: out_data=0x03.
